module_decoder: RTL and testbench
=================================

// Module: module_decoder
// PURPOSE
//  Pipelined Hamming(7,4) single-error-correcting decoder; receive-side counterpart of module_encoder.
//  - Accepts 7-bit codewords in layout {i3,i2,i1,c2,i0,c1,c0} (bit6..bit0), i.e. bit k = position k+1.
//  - Computes the syndrome, corrects any single-bit error and returns the 4 data bits plus diagnostics.
//  - Sits between the codeword source (switches/channel model) and the display/LED stage; valid/ready on both sides.
// PARAMETERS
//  CNT_W      8   width of saturating error counters (only with DECODER_ERR_STATS_EN)
// PORTS
//  clk          in   1  system clock; all state updates on rising edge
//  rst_n        in   1  reset, synchronous, active-low
//  in_valid     in   1  codeword on in_word is valid
//  in_ready     out  1  decoder can accept a codeword this cycle
//  in_word      in   7  received codeword {i3,i2,i1,c2,i0,c1,c0}
//  out_valid    out  1  decoded result valid
//  out_ready    in   1  downstream accepts result this cycle
//  data_out     out  4  corrected data {i3,i2,i1,i0}
//  syndrome     out  3  {s2,s1,s0}; 0 = no error, else erroneous position 1..7
//  err_flag     out  1  syndrome != 0 (single error detected and corrected)
//  parity_err   out  1  error was in a parity bit (syndrome 1, 2 or 4)
//  err_cnt      out  CNT_W  corrected-error count (DECODER_ERR_STATS_EN only)
//  word_cnt     out  CNT_W  accepted-codeword count (DECODER_ERR_STATS_EN only)
// BEHAVIOUR
//  - Syndrome: s0 = w0^w2^w4^w6; s1 = w1^w2^w5^w6; s2 = w3^w4^w5^w6.
//  - Correction: if syndrome != 0, invert bit (syndrome-1) of the word; data_out = {w6,w5,w4,w2} of corrected word.
//  - Two register stages. S1 captures in_word and syndrome; S2 captures data_out and flags.
//  - Latency: result appears 2 cycles after the input handshake when out_ready is held high. Throughput: 1 word/cycle.
//  - Handshakes: transfer occurs when valid && ready are both high at a clock edge.
//    - in_ready = !s1_valid || s1_adv;  s1_adv = !s2_valid || out_ready.
//    - in_ready depends only on registered state and out_ready; no combinational path from in_valid.
//  - Stall: while out_valid && !out_ready, every output is held stable. S1 holds while blocked. No word is dropped or duplicated.
//  - Simultaneous accept into S1 and drain from S2 in the same cycle is legal and keeps full throughput.
//  - Double-bit errors are miscorrected to a wrong position (Hamming(7,4) limitation). No detection is required.
//  - Reset (rst_n=0 at edge): s1_valid=0, out_valid=0, data_out=0, syndrome=0, err_flag=0, parity_err=0, counters=0.
//    - in_ready is 1 during and after reset.
//    - Reset mid-stream discards in-flight words; nothing is emitted for them.
// CONFIGURATION
//  DECODER_ERR_STATS_EN defined:
//    - word_cnt increments on each input handshake.
//    - err_cnt increments on each S2 load with syndrome != 0.
//    - Both saturate at 2**CNT_W-1 and never wrap.
//  DECODER_ERR_STATS_EN undefined:
//    - err_cnt and word_cnt ports and their logic are absent.
//    - Datapath and timing are identical to the defined case.
// STRUCTURE
//  - Shared package hamming_pkg: typedef codeword_t (logic[6:0]), data_t (logic[3:0]), syndrome_t (logic[2:0]);
//    constants SYN_NONE=3'd0, parity positions P_C0=1, P_C1=2, P_C2=4;
//    function hamming_syndrome(codeword_t) for reuse by encoder/benches.
//  - One sub-module: hamming_corrector (combinational; syndrome + codeword -> corrected data, parity_err).
// TESTING
//  1 No error: in_word=7'h55 (data 4'b1011), out_ready=1 -> 2 cycles later data_out=4'b1011, syndrome=0, err_flag=0.
//  2 Data error: in_word=7'b1010001 (bit2 flipped) -> data_out=4'b1011, syndrome=3'd3, err_flag=1, parity_err=0.
//  3 Parity error: in_word=7'b1011101 (bit3/c2 flipped) -> data_out=4'b1011, syndrome=3'd4, parity_err=1.
//  4 Back-pressure: stream 4 words, out_ready=0 for 3 cycles -> outputs held stable; in_ready=0 once both stages are full;
//    all 4 results emerge in order, none lost or duplicated.
//  5 Reset mid-stream: rst_n=0 with both stages full -> next cycle out_valid=0, in_ready=1, outputs 0; old words never emitted.
//  6 Stats (DECODER_ERR_STATS_EN, CNT_W=2): send 5 single-error words -> word_cnt=3, err_cnt=3 (saturated).
//  Bench also runs an exhaustive sweep: 16 data values x 8 error patterns (none + each single bit) checked against
//  a module_encoder reference.

Source files
------------

// File: rtl/hamming_pkg.sv
// ============================================================================
// hamming_pkg : shared Hamming(7,4) types, constants and syndrome helper
// Rev 1.0
// ============================================================================
`default_nettype none

package hamming_pkg;

  typedef logic [6:0] codeword_t;  // {i3,i2,i1,c2,i0,c1,c0}, bit k = position k+1
  typedef logic [3:0] data_t;      // {i3,i2,i1,i0}
  typedef logic [2:0] syndrome_t;  // {s2,s1,s0}

  localparam syndrome_t SYN_NONE = 3'd0;
  localparam syndrome_t P_C0     = 3'd1;
  localparam syndrome_t P_C1     = 3'd2;
  localparam syndrome_t P_C2     = 3'd4;

  function automatic syndrome_t hamming_syndrome(input codeword_t w);
    return {w[3] ^ w[4] ^ w[5] ^ w[6],
            w[1] ^ w[2] ^ w[5] ^ w[6],
            w[0] ^ w[2] ^ w[4] ^ w[6]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_corrector.sv
// ============================================================================
// hamming_corrector : flips the bit named by the syndrome, extracts data bits
// Rev 1.0
// ============================================================================
`default_nettype none

module hamming_corrector
  import hamming_pkg::*;
(
  input  codeword_t word,
  input  syndrome_t syn,
  output data_t     data,
  output logic      parity_err
);

  codeword_t flip_mask;
  codeword_t fixed;

  // A non-zero syndrome is the 1-based position of the bad bit.
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < 7; i++) begin
      flip_mask[i] = (syn == syndrome_t'(i + 1));
    end
  end

  assign fixed      = word ^ flip_mask;
  assign data       = {fixed[6], fixed[5], fixed[4], fixed[2]};
  assign parity_err = (syn == P_C0) || (syn == P_C1) || (syn == P_C2);

endmodule

`default_nettype wire

// File: rtl/module_decoder.sv
// ============================================================================
// module_decoder : two-stage Hamming(7,4) SEC decoder with valid/ready ports
// Optional DECODER_ERR_STATS_EN adds saturating err_cnt/word_cnt.  Rev 1.0
// ============================================================================
`default_nettype none

module module_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  codeword_t        in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output data_t            data_out,
  output syndrome_t        syndrome,
  output logic             err_flag,
  output logic             parity_err
`ifdef DECODER_ERR_STATS_EN
  ,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt
`endif
);

  logic      s1_valid;
  logic      s2_valid;
  logic      s1_adv;
  codeword_t s1_word;
  syndrome_t s1_syn;
  data_t     fix_data;
  logic      fix_perr;
  logic      in_fire;
  logic      s2_load;

  // Ready looks only at registered state and out_ready.
  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign in_fire   = in_valid && in_ready;
  assign s2_load   = s1_adv && s1_valid;
  assign out_valid = s2_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= SYN_NONE;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= in_word;
        s1_syn  <= hamming_syndrome(in_word);
      end
    end
  end

  hamming_corrector u_corrector (
    .word       (s1_word),
    .syn        (s1_syn),
    .data       (fix_data),
    .parity_err (fix_perr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      data_out   <= '0;
      syndrome   <= SYN_NONE;
      err_flag   <= 1'b0;
      parity_err <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_out   <= fix_data;
        syndrome   <= s1_syn;
        err_flag   <= (s1_syn != SYN_NONE);
        parity_err <= fix_perr;
      end
    end
  end

`ifdef DECODER_ERR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (in_fire && (word_cnt != '1)) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (s2_load && (s1_syn != SYN_NONE) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end
`else
  logic stats_unused;
  assign stats_unused = in_fire ^ s2_load;
  // Counter width only matters when statistics are built in.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_module_decoder.sv
// ============================================================================
// tb_module_decoder : randomized + directed check of module_decoder against a
// position-based Hamming encoder model and an in-order expected queue. Rev 1.0
// ============================================================================
`default_nettype none

module tb_module_decoder;

  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_word;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] data_out;
  logic [2:0] syndrome;
  logic       err_flag;
  logic       parity_err;
`ifdef DECODER_ERR_STATS_EN
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;
`endif

  module_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .data_out   (data_out),
    .syndrome   (syndrome),
    .err_flag   (err_flag),
    .parity_err (parity_err)
`ifdef DECODER_ERR_STATS_EN
    ,
    .err_cnt    (err_cnt),
    .word_cnt   (word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_q[$];  // {data, error position}
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out;
  logic       last_in_ready;
  logic       last_out_valid;
  int         m_words = 0;
  int         m_errs  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference encoder: data at positions 3,5,6,7; parity bit p covers positions q with q&p.
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [7:1] pos;
    logic       x;
    pos    = '0;
    pos[3] = d[0];
    pos[5] = d[1];
    pos[6] = d[2];
    pos[7] = d[3];
    for (int p = 1; p <= 4; p = p * 2) begin
      x = 1'b0;
      for (int q = 1; q <= 7; q++) begin
        if (((q & p) != 0) && (q != p)) x ^= pos[q];
      end
      pos[p] = x;
    end
    return pos[7:1];
  endfunction

  function automatic logic [6:0] corrupt(input logic [6:0] w, input logic [2:0] p);
    logic [6:0] r;
    r = w;
    if (p != 3'd0) r[p - 3'd1] = ~r[p - 3'd1];
    return r;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic iv, input logic [6:0] w, input logic [3:0] ed,
                       input logic [2:0] ep, input logic ordy);
    logic [6:0] e;
    if (prev_stall)
      check_eq("stall_hold", {out_valid, data_out, syndrome, err_flag, parity_err}, prev_out);
    in_valid  = iv;
    in_word   = w;
    out_ready = ordy;
    #1;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("data_out", data_out, e[6:3]);
        check_eq("syndrome", syndrome, e[2:0]);
        check_eq("err_flag", err_flag, e[2:0] != 0);
        check_eq("parity_err", parity_err, (e[2:0] == 1) || (e[2:0] == 2) || (e[2:0] == 4));
        if (e[2:0] != 0) m_errs++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back({ed, ep});
      m_words++;
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_valid, data_out, syndrome, err_flag, parity_err};
    @(negedge clk);
  endtask

  task automatic send(input logic [3:0] d, input logic [2:0] p, input logic ordy);
    cycle(1'b1, corrupt(encode(d), p), d, p, ordy);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 7'h00, 4'h0, 3'd0, ordy);
  endtask

  task automatic check_zero_state(input string tag);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_outputs"}, {data_out, syndrome, err_flag, parity_err}, 0);
  endtask

  task automatic directed(input logic [6:0] w, input logic [3:0] d, input logic [2:0] p);
    cycle(1'b1, w, d, p, 1'b1);
    idle(1'b1);
    check_eq("latency_early", last_out_valid, 0);
    idle(1'b1);
    check_eq("latency_on_time", last_out_valid, 1);
    check_eq("directed_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int guard;
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_state("reset");
    rst_n = 1'b1;

    directed(7'h55, 4'b1011, 3'd0);
    directed(7'b1010001, 4'b1011, 3'd3);
    directed(7'b1011101, 4'b1011, 3'd4);

    // Back-pressure: 4 words, sink stalled for 3 cycles
    send(4'h3, 3'd1, 1'b0);
    send(4'hA, 3'd6, 1'b0);
    send(4'h5, 3'd0, 1'b0);
    check_eq("full_in_ready", last_in_ready, 0);
    send(4'h5, 3'd0, 1'b0);
    guard = 0;
    while (last_in_ready == 1'b0 && guard < 20) begin
      send(4'h5, 3'd0, 1'b1);
      guard++;
    end
    send(4'hC, 3'd7, 1'b1);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin idle(1'b1); guard++; end
    check_eq("bp_drained", exp_q.size(), 0);

    // Reset with both stages full
    send(4'hF, 3'd3, 1'b0);
    send(4'hE, 3'd5, 1'b0);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check_zero_state("midreset");
    rst_n = 1'b1;
    exp_q.delete();
    prev_stall = 1'b0;
    m_words = 0;
    m_errs  = 0;
    repeat (4) idle(1'b1);

    // Exhaustive: every data value with no error and each single-bit error
    for (int d = 0; d < 16; d++)
      for (int p = 0; p < 8; p++)
        send(4'(d), 3'(p), 1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [3:0] d;
      logic [2:0] p;
      d = 4'($urandom_range(0, 15));
      p = 3'($urandom_range(0, 7));
      cycle(($urandom % 10) < 7, corrupt(encode(d), p), d, p, ($urandom % 10) < 6);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 50) begin idle(1'b1); guard++; end
    check_eq("final_drained", exp_q.size(), 0);
    idle(1'b1);

`ifdef DECODER_ERR_STATS_EN
    check_eq("word_cnt", word_cnt, (m_words > 255) ? 255 : m_words);
    check_eq("err_cnt", err_cnt, (m_errs > 255) ? 255 : m_errs);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
